cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides. Operands are split into GROUP-bit lookahead groups, and the groups are spread across STAGES register stages. Carries cross stage boundaries through pipeline registers, so wide adds (32/64-bit) close timing. It is the ALU-path adder for the datapath and replaces chains of fixed 4-bit CLA cells.

## Interface
- WIDTH, 32: operand/sum width; must be a multiple of GROUP.
- GROUP, 4: bits per lookahead group.
- STAGES, 2: pipeline stages, 1..WIDTH/GROUP; (WIDTH/GROUP) % STAGES must be 0, else elaboration fails.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in (borrow-in when subtracting).
- sub  in  1  1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum/difference.
- co  out  1  carry-out (1 = no borrow when subtracting).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

## Operation
- Accept when in_valid && in_ready. Add: {co,s} = a + b + ci.
- Subtract: s = a + ~b + ~ci, which equals a − b − ci; co = ~borrow.
- Per bit: g = a & b', p = a ^ b', where b' is the effective operand. Each group produces gm/pm and in-group carries from its group carry-in.
- Within a stage, group carries come from second-level lookahead over the group gm/pm, seeded by that stage's registered carry-in.
- Stage k (0-based) resolves slice [(k+1)·W/STAGES−1 : k·W/STAGES], where W = WIDTH. Unresolved upper operand bits (g/p) move forward in the stage registers. Resolved sum bits are carried along to the output.
- ovf = (b'[W−1] == a[W−1]) && (s[W−1] != a[W−1]).
- Per-stage valid bit. ready_k = !valid_k || ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0. Bubbles collapse.
- Results leave in acceptance order, with no loss and no duplication.
- While out_valid && !out_ready, s/co/ovf/zero stay stable.
- Reset clears all valid bits and all data/carry registers. In-flight results are discarded. s=0, co=0, ovf=0, zero=0, out_valid=0.
- in_ready is forced to 0 while rst is high.

## Timing
- Latency is exactly STAGES cycles from the accept edge to out_valid, with no stall.
- Throughput is 1 result/cycle with out_ready held high.
- Outputs are registered. in_ready is combinational from out_ready through the ready chain; there is no combinational path from a/b to outputs.
- When the pipeline is full and out_ready=0, in_ready=0. When out_ready rises, in_ready rises in the same cycle.
- Accepting and emitting in the same cycle is legal at full occupancy.
- rst asserted in any cycle: next cycle every output is at its reset value. in_ready=1 in the first cycle after rst deasserts.

## Configuration
- CLA_PIPE_SUB_EN defined: sub is honoured as above.
- Not defined: the sub port remains, but is ignored and treated as 0. The inversion logic is not built. Results are always a + b + ci.

## Structure
- Package cla_pipe_pkg holds:
  - group-count and slice-width localparam functions;
  - the elaboration-check function for the parameter constraints;
  - a packed stage-register struct type (valid, carry, resolved sum bits, pending g/p, sign bits for ovf).
- One sub-module, cla_group: parametrised GROUP-bit lookahead group; outputs sum bits, gm, pm. Instantiate it WIDTH/GROUP times.
- The second-level lookahead and the pipeline registers live in the top module.

## Test plan
Defaults WIDTH=32, GROUP=4, STAGES=2; out_ready=1 unless stated.
- Reset: rst high 2 cycles -> out_valid=0, s=0, co=0, ovf=0, zero=0, in_ready=0 during reset; in_ready=1 the cycle after release.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, ci=0 -> s=0x00000000, co=1, zero=1, ovf=0; out_valid exactly 2 cycles after accept.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ovf=1, zero=0.
- Subtract: a=5, b=7, ci=0, sub=1 -> s=0xFFFFFFFE, co=0, ovf=0 with CLA_PIPE_SUB_EN; s=0x0000000C, co=0 without it.
- Backpressure: stream 4 beats (1+1, 2+2, 3+3, 4+4) and drop out_ready for 3 cycles after the first result appears.
  - Required: s held at 2 while stalled; in_ready=0 once 2 beats are buffered.
  - Required: after release, results 2, 4, 6, 8 in order, one per cycle.
- Reset mid-flight: accept two beats, pulse rst 1 cycle before the first result -> out_valid stays 0; neither result ever appears; a new beat after reset completes in 2 cycles.

Source files
------------

// File: rtl/cla_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pipe_pkg;

  // Upper bound on WIDTH; the stage register struct is sized to this.
  localparam int unsigned CLA_MAX_W = 64;

  function automatic int unsigned group_count(input int unsigned width, input int unsigned group);
    return width / group;
  endfunction

  function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned group,
                                   input int unsigned stages);
    if (width == 0 || group == 0 || stages == 0) return 1'b0;
    if (width > CLA_MAX_W) return 1'b0;
    if ((width % group) != 0) return 1'b0;
    if (stages > (width / group)) return 1'b0;
    return ((width / group) % stages) == 0;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 a_msb;
    logic                 b_msb;
    logic [CLA_MAX_W-1:0] sum;
    logic [CLA_MAX_W-1:0] g;
    logic [CLA_MAX_W-1:0] p;
  } stage_t;

endpackage

// File: rtl/cla_pipe_adder_group.sv
// GROUP-bit lookahead cell: in-group carries from c_i, plus group generate/propagate.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] g_i,
  input  logic [GROUP-1:0] p_i,
  input  logic             c_i,
  output logic [GROUP-1:0] sum_o,
  output logic             gm_o,
  output logic             pm_o
);

  logic [GROUP-1:0] carry;
  logic             gm_acc;

  always_comb begin : carries
    carry[0] = c_i;
    for (int i = 1; i < GROUP; i++) begin
      carry[i] = g_i[i-1] | (p_i[i-1] & carry[i-1]);
    end
  end

  // Kept apart from the carry block so gm/pm never appear to depend on c_i.
  always_comb begin : group_gen
    gm_acc = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      gm_acc = g_i[i] | (p_i[i] & gm_acc);
    end
  end

  assign sum_o = p_i ^ carry;
  assign gm_o  = gm_acc;
  assign pm_o  = &p_i;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor with valid/ready on both sides.
// Define CLA_PIPE_SUB_EN to honour the sub input; otherwise it is ignored.
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NG  = group_count(WIDTH, GROUP);
  localparam int unsigned GPS = NG / STAGES;
  localparam int unsigned SW  = slice_width(WIDTH, STAGES);
  localparam int unsigned L   = STAGES - 1;

  if (!params_ok(WIDTH, GROUP, STAGES)) begin : g_param_check
    $error("cla_pipe_adder: illegal WIDTH/GROUP/STAGES combination");
  end

  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;

`ifdef CLA_PIPE_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign ci_eff = sub ? ~ci : ci;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign ci_eff     = ci;
`endif

  stage_t        in_stage;
  stage_t        src  [STAGES];
  stage_t        st_d [STAGES];
  stage_t        st_q [STAGES];
  logic [STAGES:0] ready;
  logic          ovf_d, zero_d, ovf_q, zero_q;

  always_comb begin : in_pack
    in_stage       = '0;
    in_stage.valid = in_valid;
    in_stage.carry = ci_eff;
    in_stage.a_msb = a[WIDTH-1];
    in_stage.b_msb = b_eff[WIDTH-1];
    in_stage.g     = CLA_MAX_W'(a & b_eff);
    in_stage.p     = CLA_MAX_W'(a ^ b_eff);
  end

  assign src[0]        = in_stage;
  assign ready[STAGES] = out_ready;
  assign in_ready      = ready[0] & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [GPS-1:0]       gm_s, pm_s, c_s;
    logic [SW-1:0]        sum_s;
    logic                 cout_s;
    logic [CLA_MAX_W-1:0] slice_ext;
    stage_t               nxt;

    if (k > 0) begin : g_link
      assign src[k] = st_q[k-1];
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .g_i   (src[k].g[k*SW + j*GROUP +: GROUP]),
        .p_i   (src[k].p[k*SW + j*GROUP +: GROUP]),
        .c_i   (c_s[j]),
        .sum_o (sum_s[j*GROUP +: GROUP]),
        .gm_o  (gm_s[j]),
        .pm_o  (pm_s[j])
      );
    end

    // Second-level lookahead seeded by the carry arriving with this stage's data.
    always_comb begin : lookahead
      logic c_run;
      c_run = src[k].carry;
      c_s   = '0;
      for (int j = 0; j < GPS; j++) begin
        c_s[j] = c_run;
        c_run  = gm_s[j] | (pm_s[j] & c_run);
      end
      cout_s = c_run;
    end

    always_comb begin : next_stage
      slice_ext             = '0;
      slice_ext[k*SW +: SW] = sum_s;
      nxt                   = src[k];
      nxt.carry             = cout_s;
      nxt.sum               = src[k].sum | slice_ext;
    end

    assign st_d[k]  = nxt;
    assign ready[k] = ~st_q[k].valid | ready[k+1];

    // Bubbles only clear the valid bit so held data stays quiet.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q[k] <= '0;
      end else if (ready[k]) begin
        if (st_d[k].valid) begin
          st_q[k] <= st_d[k];
        end else begin
          st_q[k].valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin : flags
    zero_d = ~|st_d[L].sum;
    ovf_d  = (st_d[L].b_msb == st_d[L].a_msb) && (st_d[L].sum[WIDTH-1] != st_d[L].a_msb);
  end

  // Flags are registered alongside the final stage so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (ready[L] && st_d[L].valid) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = st_q[L].valid;
  assign s         = st_q[L].sum[WIDTH-1:0];
  assign co        = st_q[L].carry;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=32, GROUP=4, STAGES=2).
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        ci = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] s;
  logic        co, ovf, zero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t exp_q[$];

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Plain-arithmetic reference: 64-bit unsigned for carry, 64-bit signed for overflow.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic cin, input logic do_sub);
    res_t              r;
    longint unsigned   ux, uy, t;
    longint            sx, sy, c64, sr;
    bit                sub_en;
    sub_en = 1'b0;
`ifdef CLA_PIPE_SUB_EN
    sub_en = do_sub;
`endif
    ux = x; uy = y; c64 = cin;
    sx = $signed(x); sy = $signed(y);
    if (sub_en) begin
      t    = ux - uy - c64;
      r.co = (ux >= uy + c64);
      sr   = sx - sy - c64;
    end else begin
      t    = ux + uy + c64;
      r.co = t[32];
      sr   = sx + sy + c64;
    end
    r.s    = t[31:0];
    r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] x, input logic [31:0] y,
                       input logic c, input logic sb);
    in_valid = v; a = x; b = y; ci = c; sub = sb;
  endtask

  // One clock: sample handshakes, run the scoreboard, advance to the next negedge.
  task automatic tick();
    res_t        e;
    logic [31:0] hs;
    logic        hco, hovf, hz;
    bit          hold, was_rst;
    #1;
    was_rst = rst;
    hold    = 1'b0;
    hs = 32'd0; hco = 1'b0; hovf = 1'b0; hz = 1'b0;
    if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_s", 64'(s), 64'(e.s));
        chk("sb_co", 64'(co), 64'(e.co));
        chk("sb_ovf", 64'(ovf), 64'(e.ovf));
        chk("sb_zero", 64'(zero), 64'(e.zero));
      end
    end
    if (!rst && out_valid && !out_ready) begin
      hold = 1'b1; hs = s; hco = co; hovf = ovf; hz = zero;
    end
    @(posedge clk);
    @(negedge clk);
    if (was_rst) exp_q.delete();
    if (hold && !rst) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_s", 64'(s), 64'(hs));
      chk("hold_co", 64'(co), 64'(hco));
      chk("hold_ovf", 64'(ovf), 64'(hovf));
      chk("hold_zero", 64'(zero), 64'(hz));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    // Reset held for two cycles.
    rst = 1'b1; out_ready = 1'b1; drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    tick();
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    tick();
    rst = 1'b0; drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Full carry ripple and exact latency.
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("ripple_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("ripple_valid", 64'(out_valid), 64'd1);
    chk("ripple_s", 64'(s), 64'h0);
    chk("ripple_co", 64'(co), 64'd1);
    chk("ripple_zero", 64'(zero), 64'd1);
    chk("ripple_ovf", 64'(ovf), 64'd0);

    // Signed overflow.
    drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("ovf_s", 64'(s), 64'h8000_0000);
    chk("ovf_co", 64'(co), 64'd0);
    chk("ovf_ovf", 64'(ovf), 64'd1);
    chk("ovf_zero", 64'(zero), 64'd0);

    // Subtract 5 - 7.
    drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
`ifdef CLA_PIPE_SUB_EN
    chk("sub_s", 64'(s), 64'hFFFF_FFFE);
`else
    chk("sub_s", 64'(s), 64'h0000_000C);
`endif
    chk("sub_co", 64'(co), 64'd0);
    chk("sub_ovf", 64'(ovf), 64'd0);
    tick();

    // Backpressure: four beats, out_ready low for three cycles once the first result shows.
    drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd2, 32'd2, 1'b0, 1'b0);
    tick();
    chk("bp_first_valid", 64'(out_valid), 64'd1);
    chk("bp_first_s", 64'(s), 64'd2);
    out_ready = 1'b0;
    drive(1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      tick();
      chk("bp_stall_s", 64'(s), 64'd2);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (n == 1) drive(1'b1, 32'd4, 32'd4, 1'b0, 1'b0);
      if (n >= 2) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #1;
      if (n == 0) chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
      chk("bp_order_valid", 64'(out_valid), 64'd1);
      chk("bp_order_s", 64'(s), 64'(2 * (n + 1)));
      tick();
    end

    // Reset while a beat is in flight.
    drive(1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'd30, 32'd40, 1'b0, 1'b0);
    #1;
    chk("rm_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rm_s", 64'(s), 64'd0);
    for (int n = 0; n < 3; n++) begin
      chk("rm_no_result", 64'(out_valid), 64'd0);
      tick();
    end
    drive(1'b1, 32'd100, 32'd23, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rm_new_lat1", 64'(out_valid), 64'd0);
    tick();
    chk("rm_new_valid", 64'(out_valid), 64'd1);
    chk("rm_new_s", 64'(s), 64'd124);
    tick();

    // Full throughput with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, $urandom, $urandom, 1'(i), 1'(i >> 1));
      #1;
      chk("tp_in_ready", 64'(in_ready), 64'd1);
      tick();
      if (i >= 1) chk("tp_valid", 64'(out_valid), 64'd1);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 2) != 0, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    // Drain, bounded.
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() != 0) tick();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_idle", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
